// File: rtl/id_stage_hz_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_pkg: opcodes, ALU op / immediate encodings and decode helpers     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package id_pkg;

  localparam logic [6:0] c_op_r      = 7'b0110011;
  localparam logic [6:0] c_op_i_alu  = 7'b0010011;
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLL = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SLT = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_J    = 3'd4
  } imm_type_e;

  typedef struct packed {
    logic mem_read;
    logic mem_to_reg;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic beq;
    logic bne;
    logic jal;
    logic jalr;
  } ctrl_t;

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic f7b5,
                                         input logic is_r);
    alu_op_e op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  // 32-bit sign-extended immediate; the caller widens to XLEN.
  function automatic logic [31:0] imm32(input logic [31:0] ins, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_hz_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_hz_if: IF/ID, WB and ID/EX signals of the decode stage      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface id_stage_hz_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  logic            if_valid;
  logic [31:0]     instr_d;
  logic [XLEN-1:0] pc_d;
  logic            wb_en;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            flush;
  logic            stall_d;
  logic            ex_valid;
  logic [XLEN-1:0] ex_pc;
  logic [XLEN-1:0] ex_rs1_data;
  logic [XLEN-1:0] ex_rs2_data;
  logic [XLEN-1:0] ex_imm;
  logic [4:0]      ex_rs1;
  logic [4:0]      ex_rs2;
  logic [4:0]      ex_rd;
  logic [2:0]      ex_aluop;
  logic            ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic            ex_beq, ex_bne, ex_jal, ex_jalr;
  logic            ex_illegal;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport slave (
    input  if_valid, instr_d, pc_d, wb_en, wb_rd, wb_data, flush,
    output stall_d, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_aluop, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_beq, ex_bne, ex_jal,
           ex_jalr, ex_illegal, stall_cnt, flush_cnt
  );

  modport master (
    output if_valid, instr_d, pc_d, wb_en, wb_rd, wb_data, flush,
    input  stall_d, ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
           ex_rs1, ex_rs2, ex_rd, ex_aluop, ex_mem_read, ex_mem_to_reg,
           ex_mem_write, ex_alu_src, ex_reg_write, ex_beq, ex_bne, ex_jal,
           ex_jalr, ex_illegal, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/id_stage_hz_regfile_bp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_bp: 32 x XLEN register file, x0 hardwired, optional WB bypass |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module regfile_bp #(
  parameter int XLEN      = 64,
  parameter bit BYPASS_EN = 1'b1
) (
  input  wire logic            clk,
  input  wire logic            reset_n,
  input  wire logic [4:0]      i_rs1,
  input  wire logic [4:0]      i_rs2,
  output logic [XLEN-1:0]      o_rs1_data,
  output logic [XLEN-1:0]      o_rs2_data,
  input  wire logic            i_wb_en,
  input  wire logic [4:0]      i_wb_rd,
  input  wire logic [XLEN-1:0] i_wb_data
);
  logic [XLEN-1:0] r_regs [32];
  logic [XLEN-1:0] w_rs1_raw, w_rs2_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) r_regs[i] <= '0;
    end else if (i_wb_en && (i_wb_rd != 5'd0)) begin
      r_regs[i_wb_rd] <= i_wb_data;
    end
  end

  assign w_rs1_raw = (i_rs1 == 5'd0) ? '0 : r_regs[i_rs1];
  assign w_rs2_raw = (i_rs2 == 5'd0) ? '0 : r_regs[i_rs2];

  generate
    if (BYPASS_EN) begin : g_bypass
      // x0 is never forwarded, so a dropped write cannot leak into a read.
      assign o_rs1_data = (i_wb_en && (i_wb_rd == i_rs1) && (i_rs1 != 5'd0)) ? i_wb_data : w_rs1_raw;
      assign o_rs2_data = (i_wb_en && (i_wb_rd == i_rs2) && (i_rs2 != 5'd0)) ? i_wb_data : w_rs2_raw;
    end else begin : g_no_bypass
      assign o_rs1_data = w_rs1_raw;
      assign o_rs2_data = w_rs2_raw;
    end
  endgenerate
endmodule
`default_nettype wire

// File: rtl/id_stage_hz.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage_hz: decode, load-use hazard/flush handling, ID/EX register   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module id_stage_hz
  import id_pkg::*;
#(
  parameter int XLEN      = 64,
  parameter bit BYPASS_EN = 1'b1,
  parameter int CNT_W     = 16
) (
  input wire logic     clk,
  input wire logic     reset_n,
  id_stage_hz_if.slave bus
);
  logic [6:0]      w_opcode;
  logic [4:0]      w_rs1, w_rs2;
  ctrl_t           w_ctrl;
  alu_op_e         w_aluop;
  imm_type_e       w_imm_type;
  logic            w_illegal, w_use_rs1, w_use_rs2;
  logic [XLEN-1:0] w_imm, w_rs1_data, w_rs2_data;
  logic            w_hazard, w_stall, w_bubble;

  ctrl_t            r_ex_ctrl;
  alu_op_e          r_ex_aluop;
  logic             r_ex_valid, r_ex_illegal;
  logic [XLEN-1:0]  r_ex_pc, r_ex_rs1_data, r_ex_rs2_data, r_ex_imm;
  logic [4:0]       r_ex_rs1, r_ex_rs2, r_ex_rd;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

  assign w_opcode = bus.instr_d[6:0];
  assign w_rs1    = bus.instr_d[19:15];
  assign w_rs2    = bus.instr_d[24:20];

  always_comb begin
    w_ctrl     = '0;
    w_aluop    = ALU_ADD;
    w_imm_type = IMM_NONE;
    w_illegal  = 1'b0;
    w_use_rs2  = 1'b0;
    case (w_opcode)
      c_op_r: begin
        w_ctrl.reg_write = 1'b1;
        w_aluop          = alu_decode(bus.instr_d[14:12], bus.instr_d[30], 1'b1);
        w_use_rs2        = 1'b1;
      end
      c_op_i_alu: begin
        w_ctrl.alu_src   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_aluop          = alu_decode(bus.instr_d[14:12], bus.instr_d[30], 1'b0);
        w_imm_type       = IMM_I;
      end
      c_op_load: begin
        w_ctrl.mem_read   = 1'b1;
        w_ctrl.mem_to_reg = 1'b1;
        w_ctrl.alu_src    = 1'b1;
        w_ctrl.reg_write  = 1'b1;
        w_imm_type        = IMM_I;
      end
      c_op_store: begin
        w_ctrl.mem_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_type       = IMM_S;
        w_use_rs2        = 1'b1;
      end
      c_op_branch: begin
        w_ctrl.beq = (bus.instr_d[14:12] == 3'b000);
        w_ctrl.bne = (bus.instr_d[14:12] == 3'b001);
        w_aluop    = ALU_SUB;
        w_imm_type = IMM_B;
        w_use_rs2  = 1'b1;
      end
      c_op_jal: begin
        w_ctrl.jal       = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_imm_type       = IMM_J;
      end
      c_op_jalr: begin
        w_ctrl.jalr      = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.alu_src   = 1'b1;
        w_imm_type       = IMM_I;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_use_rs1 = (w_opcode != c_op_jal);
  assign w_imm     = XLEN'($signed(imm32(bus.instr_d, w_imm_type)));

  regfile_bp #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_rs1      (w_rs1),
    .i_rs2      (w_rs2),
    .o_rs1_data (w_rs1_data),
    .o_rs2_data (w_rs2_data),
    .i_wb_en    (bus.wb_en),
    .i_wb_rd    (bus.wb_rd),
    .i_wb_data  (bus.wb_data)
  );

  // The bubble loaded during a stall clears ex_valid, so a stall never lasts beyond one cycle.
  assign w_hazard = r_ex_valid & r_ex_ctrl.mem_read & (r_ex_rd != 5'd0) & bus.if_valid &
                    ((w_use_rs1 & (r_ex_rd == w_rs1)) | (w_use_rs2 & (r_ex_rd == w_rs2)));
  assign w_stall  = w_hazard & ~bus.flush;
  assign w_bubble = bus.flush | w_hazard | ~bus.if_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ex_valid    <= 1'b0;
      r_ex_ctrl     <= '0;
      r_ex_aluop    <= ALU_ADD;
      r_ex_illegal  <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_rs1_data <= '0;
      r_ex_rs2_data <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_ex_rd       <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_ex_valid    <= ~w_bubble;
      r_ex_ctrl     <= w_bubble ? '0 : w_ctrl;
      r_ex_aluop    <= w_bubble ? ALU_ADD : w_aluop;
      r_ex_illegal  <= ~w_bubble & w_illegal;
      r_ex_pc       <= bus.pc_d;
      r_ex_rs1_data <= w_rs1_data;
      r_ex_rs2_data <= w_rs2_data;
      r_ex_imm      <= w_imm;
      r_ex_rs1      <= w_rs1;
      r_ex_rs2      <= w_rs2;
      r_ex_rd       <= bus.instr_d[11:7];
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (bus.flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign bus.stall_d       = w_stall;
  assign bus.ex_valid      = r_ex_valid;
  assign bus.ex_pc         = r_ex_pc;
  assign bus.ex_rs1_data   = r_ex_rs1_data;
  assign bus.ex_rs2_data   = r_ex_rs2_data;
  assign bus.ex_imm        = r_ex_imm;
  assign bus.ex_rs1        = r_ex_rs1;
  assign bus.ex_rs2        = r_ex_rs2;
  assign bus.ex_rd         = r_ex_rd;
  assign bus.ex_aluop      = r_ex_aluop;
  assign bus.ex_mem_read   = r_ex_ctrl.mem_read;
  assign bus.ex_mem_to_reg = r_ex_ctrl.mem_to_reg;
  assign bus.ex_mem_write  = r_ex_ctrl.mem_write;
  assign bus.ex_alu_src    = r_ex_ctrl.alu_src;
  assign bus.ex_reg_write  = r_ex_ctrl.reg_write;
  assign bus.ex_beq        = r_ex_ctrl.beq;
  assign bus.ex_bne        = r_ex_ctrl.bne;
  assign bus.ex_jal        = r_ex_ctrl.jal;
  assign bus.ex_jalr       = r_ex_ctrl.jalr;
  assign bus.ex_illegal    = r_ex_illegal;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;
endmodule
`default_nettype wire
